fft_loader: RTL
===============

# fft_loader

Windowing and load stage between the I2S receiver and the FFT core. It takes left-channel samples from `i2s`, scales each by the Hann coefficient from the external `hann_lut`, and writes the results as complex words into FFT RAM at bit-reversed addresses. After N samples it pulses `fft_start` and ignores input until the FFT reports done.

## Interface
- `width`, 16: data width per real/imag component (Q1.15).
- `N_2`, 5: log2 of FFT length; N = 2^N_2 = 32.

- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `sample_valid`  in  1: one-cycle strobe; `sample` is valid this cycle.
- `sample`  in  24: signed left-channel sample from `i2s`.
- `fft_done`  in  1: one-cycle pulse from the FFT AGU when the transform finishes.
- `hann_idx`  out  N_2: registered index into `hann_lut`.
- `hann_coef`  in  width: LUT output; valid one cycle after `hann_idx` changes.
- `load_we`  out  1: RAM write enable.
- `load_adr`  out  N_2: RAM write address, bit-reversed sample index.
- `load_wd`  out  2*width: write data, packed {real, imag}; imag is always 0.
- `fft_start`  out  1: one-cycle pulse after the Nth write.
- `overrun`  out  1: sticky flag; a sample arrived while not accepting.

## Operation
- States: FILL, BUSY. Reset state: FILL, count = 0.
- FILL, `sample_valid`=1: accept.
  - Capture `sample[23:24-width]` (top `width` bits) into the stage-1 register.
  - Set `hann_idx` = count and increment count.
- Stage 2, one cycle later: `hann_coef` is valid.
  - Product = signed(sample) × coef. Treat coef as signed; the LUT guarantees ≤ 0x7FFF.
  - Result = (product >>> 15)[width-1:0]: arithmetic shift, truncation toward −∞, no saturation needed.
- Stage 3: register `load_wd` = {result, 0}, `load_adr` = bitrev(index), `load_we` = 1 for exactly one cycle.
- After the N−1 index is accepted, state → BUSY immediately. Samples that arrive after this are not accepted.
- `fft_start` is high for one cycle, in the cycle after `load_we` is high for index N−1.
- BUSY: `sample_valid` sets `overrun`; the sample is dropped. On `fft_done`: state → FILL, count = 0.
- `fft_done` in the same cycle as `sample_valid`: the sample is dropped and `overrun` is set. FILL takes effect the next cycle.
- `fft_done` while in FILL is ignored.
- Count wraps N−1 → 0 only on transition to BUSY. It never wraps inside FILL.
- `overrun` clears only on `reset`.

## Timing
- Reset values: `hann_idx`=0, `load_we`=0, `load_adr`=0, `load_wd`=0, `fft_start`=0, `overrun`=0. Pipeline valid bits are 0.
- Latency: `sample_valid` at edge t → `load_we` high in the cycle after edge t+2 (the RAM writes at edge t+3).
- Throughput: one sample per cycle, back-to-back strobes allowed. I2S normally delivers one per frame.
- Reset mid-fill discards all pipeline contents. No partial write or `fft_start` follows.
- `fft_start` is never asserted in the same cycle as `load_we`.

## Structure
- Shared package `fft_pkg`:
  - `loader_state_t` enum {FILL, BUSY}.
  - `function bitrev(input [N_2-1:0])`, parameterized by `N_2`.
  - Q-format constant `QSHIFT = width-1`.
- No sub-module: a 3-stage pipeline plus a 2-state FSM in one module. `hann_lut` and `twoport_RAM` are instantiated at top level.

## Test plan
- Reset, then idle 20 cycles → all outputs 0, state FILL.
- One sample 24'h400000, `hann_coef` forced 16'h7FFF → `load_we` 3 edges later; `load_adr`=0; `load_wd`={16'h3FFF,16'h0000}.
- Sample 24'hC00000 with coef 16'h4000 → real part 16'hE000 (−0.25). Checks sign and truncation.
- 32 consecutive strobes, index k → writes at bitrev(k): index 1 → adr 16, index 3 → adr 24. `fft_start` pulses once, one cycle after the last write.
- Strobe while BUSY → no write, `overrun`=1. Pulse `fft_done`, then 32 samples → normal fill and second `fft_start`; `overrun` stays 1.
- Assert `reset` after 10 samples, mid-pipeline → no further `load_we`; the next fill starts at index 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT front end: loader FSM states,
// Q-format constants and the bit-reversal used for in-place FFT addressing.
package fft_pkg;

    localparam int unsigned FFT_WIDTH = 16;
    localparam int unsigned FFT_N_2   = 5;
    localparam int unsigned QSHIFT    = FFT_WIDTH - 1;

    typedef enum logic {
        FILL = 1'b0,
        BUSY = 1'b1
    } loader_state_t;

    function automatic logic [FFT_N_2-1:0] bitrev(input logic [FFT_N_2-1:0] a);
        logic [FFT_N_2-1:0] r;
        r = '0;
        for (int i = 0; i < int'(FFT_N_2); i++) begin
            r[FFT_N_2-1-i] = a[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_loader.sv
// Hann-window and load stage: scales incoming samples by the LUT coefficient
// and writes complex words to FFT RAM at bit-reversed addresses.
module fft_loader
    import fft_pkg::*;
#(
    parameter int unsigned width = FFT_WIDTH,
    parameter int unsigned N_2   = FFT_N_2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [23:0]          sample,
    input  logic                 fft_done,
    output logic [N_2-1:0]       hann_idx,
    input  logic [width-1:0]     hann_coef,
    output logic                 load_we,
    output logic [N_2-1:0]       load_adr,
    output logic [2*width-1:0]   load_wd,
    output logic                 fft_start,
    output logic                 overrun
);

    localparam int unsigned N = 1 << N_2;

    loader_state_t state, state_nxt;
    logic          accept_c;
    logic          last_c;
    logic [N_2-1:0] count;

    // stage 1: captured sample, waiting for the LUT coefficient
    logic                    s1_valid;
    logic                    s1_last;
    logic signed [width-1:0] s1_sample;
    logic [N_2-1:0]          s1_idx;

    // stage 2: windowed result
    logic                    s2_valid;
    logic                    s2_last;
    logic [width-1:0]        s2_result;
    logic [N_2-1:0]          s2_idx;

    logic                    out_last;

    logic signed [2*width-1:0] prod_c;
    logic signed [2*width-1:0] shifted_c;
    logic                      unused_lsb_c;

    assign unused_lsb_c = ^sample[23-width:0];
    assign last_c       = (count == N_2'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        case (state)
            FILL: begin
                if (sample_valid) begin
                    accept_c = 1'b1;
                    if (last_c) begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (fft_done) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // count wraps only when the final index moves us to BUSY
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            hann_idx <= '0;
            overrun  <= 1'b0;
        end else begin
            if (accept_c) begin
                hann_idx <= count;
                count    <= last_c ? '0 : count + N_2'(1);
            end else if (state == BUSY && fft_done) begin
                count <= '0;
            end
            if (state == BUSY && sample_valid) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_sample <= '0;
            s1_idx    <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_last   <= last_c;
                s1_sample <= sample[23 -: width];
                s1_idx    <= count;
            end
        end
    end

    // coefficient is at most 0x7FFF, so the shifted product always fits width
    assign prod_c    = s1_sample * $signed(hann_coef);
    assign shifted_c = prod_c >>> QSHIFT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_result <= '0;
            s2_idx    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last   <= s1_last;
                s2_result <= shifted_c[width-1:0];
                s2_idx    <= s1_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_we   <= 1'b0;
            load_adr  <= '0;
            load_wd   <= '0;
            out_last  <= 1'b0;
            fft_start <= 1'b0;
        end else begin
            load_we   <= s2_valid;
            out_last  <= s2_valid & s2_last;
            fft_start <= load_we & out_last;
            if (s2_valid) begin
                load_adr <= bitrev(s2_idx);
                load_wd  <= {s2_result, width'(0)};
            end
        end
    end

endmodule
